// File: rtl/mem8x16_initiator_if.sv
// Request/response, fill and memory strobe bundle for the row-memory initiator.
interface mem8x16_initiator_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              fill_start;
    logic [DATA_W-1:0] fill_data;
    logic              fill_done;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Core plus memory side: drives requests and read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, fill_start, fill_data, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, fill_done,
        input  mem_cs, mem_we, mem_addr, mem_din
    );

    // Initiator side: sole driver of responses and memory strobes.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_data, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, fill_done,
        output mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem8x16_initiator.sv
// Bus initiator for the 16-bit row memory: turns valid/ready requests into
// cs/we/addr/din strobe sequences, captures read data, and runs a boot fill.
module mem8x16_initiator #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_ROWS = 7
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    mem8x16_initiator_if.slave  io_bus
);
    localparam logic [ADDR_W:0]   RowsExt = (ADDR_W + 1)'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StRdAcc, StRdCap, StErr
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_fill_done;
    logic              r_fill;
    logic [ADDR_W-1:0] r_row;
    logic              r_mem_cs;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;

    logic w_accept;
    logic w_unmapped;

    assign w_accept   = r_ready & (io_bus.req_valid | io_bus.fill_start);
    // One extra bit so NUM_ROWS == 2**ADDR_W still compares correctly.
    assign w_unmapped = ({1'b0, io_bus.req_addr} >= RowsExt);

    // Single FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill      <= 1'b0;
            r_row       <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_fill_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (io_bus.fill_start) begin
                            // mem_din doubles as the latched fill value.
                            r_fill     <= 1'b1;
                            r_row      <= '0;
                            r_mem_addr <= '0;
                            r_mem_din  <= io_bus.fill_data;
                            r_state    <= StSetup;
                        end else if (w_unmapped) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= StErr;
                        end else if (io_bus.req_we) begin
                            r_fill     <= 1'b0;
                            r_mem_addr <= io_bus.req_addr;
                            r_mem_din  <= io_bus.req_wdata;
                            r_state    <= StSetup;
                        end else begin
                            r_mem_addr <= io_bus.req_addr;
                            r_mem_cs   <= 1'b1;
                            r_state    <= StRdAcc;
                        end
                    end
                end
                StSetup: begin
                    r_mem_cs <= 1'b1;
                    r_mem_we <= 1'b1;
                    r_state  <= StStrobe;
                end
                StStrobe: begin
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (!r_fill) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                    r_state <= StHold;
                end
                StHold: begin
                    if (r_fill && (r_row != LastRow)) begin
                        r_row      <= r_row + ADDR_W'(1);
                        r_mem_addr <= r_row + ADDR_W'(1);
                        r_state    <= StSetup;
                    end else begin
                        r_fill_done <= r_fill;
                        r_fill      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                StRdAcc: begin
                    r_state <= StRdCap;
                end
                StRdCap: begin
                    r_mem_cs    <= 1'b0;
                    r_rsp_rdata <= io_bus.mem_dout;
                    r_rsp_valid <= 1'b1;
                    r_ready     <= 1'b1;
                    r_state     <= StIdle;
                end
                StErr: begin
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.req_ready = r_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rsp_rdata;
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.fill_done = r_fill_done;
    assign io_bus.mem_cs    = r_mem_cs;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_din   = r_mem_din;
endmodule
